// File: rtl/trigger_window_gate_pkg.sv
// Shared definitions for the trigger window gate: FSM state encoding and
// the default width used for the config values and event counters.
package trigger_window_gate_pkg;

    localparam int CNT_WIDTH_DEF = 16;

    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_DELAY_ENC   = 2'd1;
    localparam logic [1:0] ST_WINDOW_ENC  = 2'd2;
    localparam logic [1:0] ST_HOLDOFF_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_DELAY   = ST_DELAY_ENC,
        ST_WINDOW  = ST_WINDOW_ENC,
        ST_HOLDOFF = ST_HOLDOFF_ENC
    } state_t;

endpackage

// File: rtl/trigger_window_gate_sat_counter.sv
// Width-parameterised event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: advance on enable unless already saturated.
    always_comb begin
        count_d = count_q;
        if (en && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/trigger_window_gate.sv
// Trigger window gate: after an accepted trigger, waits a latched delay,
// forwards a window of valid samples to an AXI-Stream master (tlast on the
// final one), then holds off before re-arming.
//
// state   | meaning
// IDLE    | armed, waiting for a trigger
// DELAY   | counting down latched delay (lasts delay+1 cycles)
// WINDOW  | capturing valid samples until the window count is reached
// HOLDOFF | counting down latched holdoff (lasts holdoff+1 cycles)
module trigger_window_gate
    import trigger_window_gate_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int CNT_WIDTH        = CNT_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        trigger,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic [CNT_WIDTH-1:0]        cfg_delay,
    input  logic [CNT_WIDTH-1:0]        cfg_window,
    input  logic [CNT_WIDTH-1:0]        cfg_holdoff,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic                        busy,
    output logic [CNT_WIDTH-1:0]        trig_count,
    output logic [CNT_WIDTH-1:0]        missed_count,
    output logic                        overrun
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                      state_q, state_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]        win_q, win_d;
    logic [CNT_WIDTH-1:0]        hold_q, hold_d;
    logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                        tvalid_q, tvalid_d;
    logic                        tlast_q, tlast_d;
    logic                        overrun_q, overrun_d;
    logic                        accept;
    logic                        missed;
    logic                        capture;

    assign accept  = trigger && (state_q == ST_IDLE);
    assign missed  = trigger && (state_q != ST_IDLE);
    assign capture = (state_q == ST_WINDOW) && s_axis_tvalid;

    // Next-state, shared down-counter and output beat computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        hold_d    = hold_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        overrun_d = overrun_q;

        unique case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    cnt_d   = cfg_delay;
                    win_d   = cfg_window;
                    hold_d  = cfg_holdoff;
                    state_d = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (cnt_q == '0) begin
                    if (win_q == '0) begin
                        cnt_d   = hold_q;
                        state_d = ST_HOLDOFF;
                    end else begin
                        cnt_d   = win_q;
                        state_d = ST_WINDOW;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_WINDOW: begin
                if (s_axis_tvalid) begin
                    if (cnt_q == CNT_ONE) begin
                        cnt_d   = hold_q;
                        state_d = ST_HOLDOFF;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A completed handshake retires the beat; a capture in the same
        // cycle reloads it below.
        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end
        if (capture) begin
            tdata_d  = s_axis_tdata;
            tvalid_d = 1'b1;
            tlast_d  = (cnt_q == CNT_ONE);
            if (tvalid_q && !m_axis_tready) begin
                overrun_d = 1'b1;
            end
        end
    end

    // State and output registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            win_q     <= '0;
            hold_q    <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_q     <= win_d;
            hold_q    <= hold_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            overrun_q <= overrun_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_trig_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .count (trig_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_missed_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (missed),
        .count (missed_count)
    );

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = (state_q != ST_IDLE);
    assign overrun       = overrun_q;

endmodule
